// File: rtl/hex_display_scheduler.sv
// Time-shares the eight HEX digits between N_REQ requesters: round-robin grants held for DWELL
// cycles, urgent preemption, and registered active-low 7-segment encoding of the owner's nibbles.
module hex_display_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DWELL = 50000,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [N_REQ-1:0]     urgent_i,
  input  logic [N_REQ*32-1:0]  data_i,
  input  logic [N_REQ*8-1:0]   blank_i,
  output logic [N_REQ-1:0]     grant_o,
  output logic [N_REQ-1:0]     done_o,
  output logic [55:0]          hex_o
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StShow} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [55:0]       hex_q, hex_d;

  // Lowest-index urgent requester wins; otherwise first requester at or after start (wrapping).
  function automatic logic [IdxW-1:0] pick(input logic [N_REQ-1:0] req,
                                           input logic [N_REQ-1:0] urg,
                                           input logic [IdxW-1:0]  start);
    logic            found;
    int unsigned     k;
    logic [IdxW-1:0] kk;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      kk = IdxW'(i);
      if (!found && urg[kk]) begin
        pick  = kk;
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k  = (32'(start) + i) % N_REQ;
      kk = IdxW'(k);
      if (!found && req[kk]) begin
        pick  = kk;
        found = 1'b1;
      end
    end
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0:    seg7 = 7'b1000000;
      4'h1:    seg7 = 7'b1111001;
      4'h2:    seg7 = 7'b0100100;
      4'h3:    seg7 = 7'b0110000;
      4'h4:    seg7 = 7'b0011001;
      4'h5:    seg7 = 7'b0010010;
      4'h6:    seg7 = 7'b0000010;
      4'h7:    seg7 = 7'b1111000;
      4'h8:    seg7 = 7'b0000000;
      4'h9:    seg7 = 7'b0010000;
      4'hA:    seg7 = 7'b0001000;
      4'hB:    seg7 = 7'b0000011;
      4'hC:    seg7 = 7'b1000110;
      4'hD:    seg7 = 7'b0100001;
      4'hE:    seg7 = 7'b0000110;
      default: seg7 = 7'b0001110;
    endcase
  endfunction

  logic             own_req, own_urg, expiry;
  logic [N_REQ-1:0] urg_v, others, cand, urg_others;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    done_o     = '0;
    urg_v      = urgent_i & req_i;
    own_req    = |(req_i & grant_q);
    own_urg    = |(urg_v & grant_q);
    expiry     = (cnt_q == CNT_W'(DWELL - 1));
    others     = req_i & ~grant_q;
    urg_others = urg_v & ~grant_q;
    // The outgoing owner may only re-win when nobody else is asking.
    cand       = (others != '0) ? others : req_i;

    unique case (state_q)
      StIdle: begin
        if (req_i != '0) begin
          state_d = StShow;
          owner_d = pick(req_i, urg_v, rr_q);
          cnt_d   = '0;
        end
      end
      default: begin
        if (!own_req || expiry) begin
          if (own_req) done_o = grant_q;
          rr_d  = (owner_q == IdxW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
          cnt_d = '0;
          if (req_i != '0) begin
            owner_d = pick(cand, urg_v & cand, rr_d);
          end else begin
            state_d = StIdle;
          end
        end else if (!own_urg && (urg_others != '0)) begin
          owner_d = pick(urg_others, urg_others, rr_q);
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    grant_d = '0;
    hex_d   = '1;
    if (state_d == StShow) begin
      grant_d = N_REQ'(1) << owner_d;
      for (int unsigned d = 0; d < 8; d++) begin
        if (!blank_i[8 * 32'(owner_d) + d]) begin
          hex_d[7*d +: 7] = seg7(data_i[32 * 32'(owner_d) + 4 * d +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      hex_q   <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      hex_q   <= hex_d;
    end
  end

  assign grant_o = grant_q;
  assign hex_o   = hex_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: stimulus queues expected outputs tagged with a cycle,
// a negedge monitor pops and compares them.
module tb_hex_display_scheduler;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned CW = 4;

  localparam logic [55:0] Dark = {56{1'b1}};
  localparam logic [55:0] Hex16 = {42'h3FF_FFFF_FFFF, 7'b1111001, 7'b0000010};
  localparam logic [55:0] HexAbc = {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001,
                                    7'b0000110, 7'b0001110, 7'b1000000, 7'b1111001};
  localparam int KGrant = 0;
  localparam int KDone  = 1;
  localparam int KHex   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [N-1:0]      urg = '0;
  logic [N*32-1:0]   data = '0;
  logic [N*8-1:0]    blank = '0;
  logic [N-1:0]      grant;
  logic [N-1:0]      done;
  logic [55:0]       hex;

  hex_display_scheduler #(.N_REQ(N), .DWELL(DW), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .urgent_i (urg),
    .data_i   (data),
    .blank_i  (blank),
    .grant_o  (grant),
    .done_o   (done),
    .hex_o    (hex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          tgt;
    int          kind;
    logic [55:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int off, input int kind, input logic [55:0] v, input string nm);
    exp_t e;
    e.tgt  = cyc + off;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    urg = '0;
    step(1);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [55:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tgt == cyc) begin
        if (sb[i].kind == KGrant)     act = 56'(grant);
        else if (sb[i].kind == KDone) act = 56'(done);
        else                          act = hex;
        checks++;
        if (act !== sb[i].val) begin
          failures++;
          $display("FAIL %s cycle=%0d actual=%h required=%h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    // Reset state, no requests
    step(2);
    rst = 1'b0;
    expect_at(1, KGrant, 56'(4'b0000), "reset_grant");
    expect_at(1, KHex, Dark, "reset_hex");
    expect_at(1, KDone, 56'(4'b0000), "reset_done");
    expect_at(3, KGrant, 56'(4'b0000), "idle_grant_held");
    expect_at(3, KHex, Dark, "idle_hex_held");
    step(4);

    // Single requester, blanking and periodic done
    do_reset();
    req = 4'b0001;
    data[31:0] = 32'h0000_0016;
    blank[7:0] = 8'hFC;
    expect_at(1, KGrant, 56'(4'b0001), "single_grant");
    expect_at(1, KHex, Hex16, "single_hex_first");
    expect_at(3, KHex, Hex16, "single_hex_live");
    expect_at(3, KDone, 56'(4'b0000), "single_no_early_done");
    expect_at(4, KDone, 56'(4'b0001), "single_done_1");
    expect_at(5, KDone, 56'(4'b0000), "single_done_pulse_width");
    expect_at(5, KGrant, 56'(4'b0001), "single_rewin");
    expect_at(8, KDone, 56'(4'b0001), "single_done_2");
    step(9);

    // Round robin over 0,1,3
    do_reset();
    req = 4'b1011;
    expect_at(1, KGrant, 56'(4'b0001), "rr_grant0");
    expect_at(4, KDone, 56'(4'b0001), "rr_done0");
    expect_at(5, KGrant, 56'(4'b0010), "rr_grant1");
    expect_at(8, KDone, 56'(4'b0010), "rr_done1");
    expect_at(9, KGrant, 56'(4'b1000), "rr_grant3");
    expect_at(12, KDone, 56'(4'b1000), "rr_done3");
    expect_at(13, KGrant, 56'(4'b0001), "rr_grant0_again");
    step(14);

    // Urgent preemption, then urgent owner resists preemption
    do_reset();
    req = 4'b0001;
    expect_at(1, KGrant, 56'(4'b0001), "pre_grant0");
    step(2);
    req = 4'b0101;
    urg = 4'b0100;
    expect_at(1, KGrant, 56'(4'b0100), "preempt_grant2");
    expect_at(1, KDone, 56'(4'b0000), "preempt_no_done");
    step(1);
    urg = 4'b0101;
    expect_at(1, KGrant, 56'(4'b0100), "urgent_owner_hold1");
    expect_at(2, KGrant, 56'(4'b0100), "urgent_owner_hold2");
    expect_at(3, KDone, 56'(4'b0100), "urgent_owner_done");
    expect_at(4, KGrant, 56'(4'b0001), "urgent_after_expiry");
    step(5);

    // Owner drops request mid-dwell
    do_reset();
    req = 4'b1010;
    expect_at(1, KGrant, 56'(4'b0010), "drop_grant1");
    step(3);
    req = 4'b1000;
    expect_at(1, KGrant, 56'(4'b1000), "drop_grant3");
    expect_at(1, KDone, 56'(4'b0000), "drop_no_done");
    step(3);

    // Reset mid-dwell, counter restarts
    do_reset();
    req = 4'b0001;
    data[31:0] = 32'hABCD_EF01;
    blank[7:0] = 8'h00;
    expect_at(2, KHex, HexAbc, "hex_all_digits");
    step(2);
    rst = 1'b1;
    expect_at(1, KGrant, 56'(4'b0000), "midrst_grant");
    expect_at(1, KHex, Dark, "midrst_hex");
    step(1);
    rst = 1'b0;
    expect_at(1, KGrant, 56'(4'b0001), "postrst_grant");
    expect_at(3, KDone, 56'(4'b0000), "postrst_no_early_done");
    expect_at(4, KDone, 56'(4'b0001), "postrst_done");
    step(6);

    step(2);
    if (sb.size() != 0) begin
      checks += sb.size();
      failures += sb.size();
      $display("FAIL unchecked_expectations actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
